bank_xbar_credit_ctrl: RTL

Per-bank controller that owns the return path from the SRAM controller to the crossbar and the per-channel crossbar credits.
- Tracks credits for each read-return channel and tells the ISU whether that channel may issue.
- Decrements a channel's credit when the ISU issues to it; increments it when the xbar returns a credit.
- Buffers return beats from the SRAM controller in a 2-entry FIFO before handing them to the xbar with valid/ready.
- Replaces the fake xbar model and drives the ISU xbar_isu_chN_credit inputs.

---
 rtl/bank_pkg.sv | 17 +
 rtl/bank_rtn_fifo.sv | 52 +++++
 rtl/bank_xbar_credit_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared types and widths for the bank return path (SRAM controller -> crossbar).
package bank_pkg;

    localparam int CH_ID_W     = 2;
    localparam int ROB_W       = 3;
    localparam int DATA_W      = 128;
    localparam int NUM_CH_DFLT = 3;

    typedef struct packed {
        logic [CH_ID_W-1:0] ch_id;
        logic [ROB_W-1:0]   rob_num;
        logic [DATA_W-1:0]  data;
    } xbar_rtn_beat_t;

    localparam int BEAT_W = $bits(xbar_rtn_beat_t);

endpackage

// File: rtl/bank_rtn_fifo.sv
// Generic 2-entry registered valid/ready FIFO. The push-side ready depends only
// on the registered count, so there is no combinational path from pop ready.
module bank_rtn_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push_valid,
    output logic         o_push_ready,
    input  logic [W-1:0] i_push_data,
    output logic         o_pop_valid,
    input  logic         i_pop_ready,
    output logic [W-1:0] o_pop_data
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign o_push_ready = (r_count != 2'd2);
    assign o_pop_valid  = (r_count != 2'd0);
    assign o_pop_data   = r_mem[r_rd_ptr];
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = o_pop_valid & i_pop_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bank_xbar_credit_ctrl.sv
// Per-bank crossbar credit tracking and return-beat buffering.
// Optional per-channel popped-beat statistics: define BANK_XBAR_CREDIT_STAT_EN.
module bank_xbar_credit_ctrl
    import bank_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DFLT,
    parameter int CREDIT_W    = 3,
    parameter int CREDIT_INIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                isu_issue_fire_i,
    input  logic [CH_ID_W-1:0]  isu_issue_ch_i,
    output logic [NUM_CH-1:0]   xbar_isu_credit_o,
    input  logic                sc_xbar_valid_i,
    output logic                sc_xbar_ready_o,
    input  logic [CH_ID_W-1:0]  sc_xbar_channel_id_i,
    input  logic [ROB_W-1:0]    sc_xbar_rob_num_i,
    input  logic [DATA_W-1:0]   sc_xbar_data_i,
    output logic                xbar_valid_o,
    input  logic                xbar_ready_i,
    output logic [CH_ID_W-1:0]  xbar_channel_id_o,
    output logic [ROB_W-1:0]    xbar_rob_num_o,
    output logic [DATA_W-1:0]   xbar_data_o,
    input  logic [NUM_CH-1:0]   xbar_credit_rtn_i,
    output logic                credit_err_o
`ifdef BANK_XBAR_CREDIT_STAT_EN
    ,
    output logic [16*NUM_CH-1:0] stat_beats_o
`endif
);

    logic [NUM_CH-1:0] w_ch_err;
    logic              w_bad_ch;
    logic              r_err;
    xbar_rtn_beat_t    w_push_beat;
    xbar_rtn_beat_t    w_head_beat;

    assign w_bad_ch = isu_issue_fire_i & (int'(isu_issue_ch_i) >= NUM_CH);

    // Simultaneous issue and return cancel out, even at the counter limits.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_credit
        logic [CREDIT_W-1:0] r_cnt;
        logic                w_dec;
        logic                w_inc;
        logic                w_at_zero;
        logic                w_at_max;

        assign w_dec     = isu_issue_fire_i & (int'(isu_issue_ch_i) == n);
        assign w_inc     = xbar_credit_rtn_i[n];
        assign w_at_zero = (r_cnt == '0);
        assign w_at_max  = (r_cnt == CREDIT_W'(CREDIT_INIT));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt <= CREDIT_W'(CREDIT_INIT);
            end else if (w_dec && !w_inc && !w_at_zero) begin
                r_cnt <= r_cnt - CREDIT_W'(1);
            end else if (w_inc && !w_dec && !w_at_max) begin
                r_cnt <= r_cnt + CREDIT_W'(1);
            end
        end

        assign w_ch_err[n]          = (w_dec & ~w_inc & w_at_zero) | (w_inc & ~w_dec & w_at_max);
        assign xbar_isu_credit_o[n] = ~w_at_zero;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | (|w_ch_err) | w_bad_ch;
        end
    end

    assign credit_err_o = r_err;

    assign w_push_beat = '{ch_id: sc_xbar_channel_id_i, rob_num: sc_xbar_rob_num_i, data: sc_xbar_data_i};

    bank_rtn_fifo #(
        .W (BEAT_W)
    ) u_rtn_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_push_valid (sc_xbar_valid_i),
        .o_push_ready (sc_xbar_ready_o),
        .i_push_data  (w_push_beat),
        .o_pop_valid  (xbar_valid_o),
        .i_pop_ready  (xbar_ready_i),
        .o_pop_data   (w_head_beat)
    );

    assign xbar_channel_id_o = w_head_beat.ch_id;
    assign xbar_rob_num_o    = w_head_beat.rob_num;
    assign xbar_data_o       = w_head_beat.data;

`ifdef BANK_XBAR_CREDIT_STAT_EN
    logic w_pop;

    assign w_pop = xbar_valid_o & xbar_ready_i;

    // Beats tagged with an out-of-range channel are passed through but not counted.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_stat
        logic [15:0] r_beats;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_beats <= '0;
            end else if (w_pop && (int'(w_head_beat.ch_id) == n)) begin
                r_beats <= r_beats + 16'd1;
            end
        end

        assign stat_beats_o[16*n +: 16] = r_beats;
    end
`endif

endmodule
